fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the pipelined OTTER core. Owns the PC and the
//   instruction-memory request handshake, and presents the fetch register
//   (FR_MEM / FR_PC / FR_PC_4 / FR_VALID) to decode. A one-entry skid buffer
//   catches an instruction that returns while decode is stalled, so nothing
//   is lost or delivered twice. Redirects from execute flush the fetch
//   register and skid. A request that is still outstanding when a redirect
//   arrives is drained (its data is dropped) before the new PC is fetched.
//
// Ports
//   REG_CLOCK    in   1   clock, all state on posedge
//   REG_RESET    in   1   asynchronous active-high reset
//   STALL        in   1   hazard unit: hold fetch register contents
//   REDIRECT_EN  in   1   execute: taken branch/jump
//   REDIRECT_PC  in  32   redirect target (bits [1:0] ignored)
//   IMEM_REQ     out  1   instruction-memory request
//   IMEM_ADDR    out 32   word-aligned fetch address
//   IMEM_ACK     in   1   IMEM_DATA valid this cycle (may coincide with REQ)
//   IMEM_DATA    in  32   instruction word
//   FR_MEM       out 32   fetched instruction (NOP_INSTR when invalid)
//   FR_PC        out 32   PC of FR_MEM
//   FR_PC_4      out 32   FR_PC + 4, modulo 2^32
//   FR_VALID     out  1   fetch register holds a real instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic        REG_CLOCK,
   input  logic        REG_RESET,
   input  logic        STALL,
   input  logic        REDIRECT_EN,
   input  logic [31:0] REDIRECT_PC,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_ACK,
   input  logic [31:0] IMEM_DATA,
   output logic [31:0] FR_MEM,
   output logic [31:0] FR_PC,
   output logic [31:0] FR_PC_4,
   output logic        FR_VALID
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_FETCH   = 2'd1;
   localparam logic [1:0] ST_HOLD    = 2'd2;
   localparam logic [1:0] ST_DISCARD = 2'd3;

   typedef struct packed {
      logic [31:0] mem;
      logic [31:0] pc;
      logic [31:0] pc_4;
      logic        valid;
   } fr_t;

   typedef struct packed {
      logic [31:0] mem;
      logic [31:0] pc;
   } skid_t;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   // Address of the request being drained in DISCARD; pc_q already holds
   // the redirect target by then, but the memory must see a stable address.
   logic [31:0] disc_addr_q, disc_addr_d;
   fr_t         fr_q, fr_d;
   skid_t       skid_q, skid_d;

   logic [31:0] pc_plus4;
   logic [31:0] redir_tgt;

   assign pc_plus4  = pc_q + 32'd4;
   assign redir_tgt = {REDIRECT_PC[31:2], 2'b00};

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      disc_addr_d = disc_addr_q;
      fr_d        = fr_q;
      skid_d      = skid_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end

         ST_FETCH: begin
            if (IMEM_ACK) begin
               pc_d = pc_plus4;
               // STALL only protects a valid fetch register; an empty one
               // can always absorb the returning word.
               if (STALL && fr_q.valid) begin
                  skid_d.mem = IMEM_DATA;
                  skid_d.pc  = pc_q;
                  state_d    = ST_HOLD;
               end else begin
                  fr_d.mem   = IMEM_DATA;
                  fr_d.pc    = pc_q;
                  fr_d.pc_4  = pc_plus4;
                  fr_d.valid = 1'b1;
               end
            end else if (!STALL) begin
               fr_d.valid = 1'b0;
               fr_d.mem   = NOP_INSTR;
            end
         end

         ST_HOLD: begin
            if (!STALL) begin
               fr_d.mem   = skid_q.mem;
               fr_d.pc    = skid_q.pc;
               fr_d.pc_4  = skid_q.pc + 32'd4;
               fr_d.valid = 1'b1;
               skid_d     = '0;
               state_d    = ST_FETCH;
            end
         end

         ST_DISCARD: begin
            // Returned word belongs to the flushed path; just consume the ACK.
            if (IMEM_ACK) state_d = ST_FETCH;
         end

         default: state_d = ST_IDLE;
      endcase

      // Redirect overrides everything decided above.
      if (REDIRECT_EN) begin
         pc_d       = redir_tgt;
         fr_d.valid = 1'b0;
         fr_d.mem   = NOP_INSTR;
         skid_d     = '0;
         if (state_q == ST_FETCH && !IMEM_ACK) begin
            state_d     = ST_DISCARD;
            disc_addr_d = pc_q;
         end else if (state_q == ST_DISCARD && !IMEM_ACK) begin
            state_d = ST_DISCARD;
         end else begin
            state_d = ST_FETCH;
         end
      end
   end

   always_ff @(posedge REG_CLOCK or posedge REG_RESET) begin
      if (REG_RESET) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_VECTOR;
         disc_addr_q <= RESET_VECTOR;
         fr_q.mem    <= NOP_INSTR;
         fr_q.pc     <= '0;
         fr_q.pc_4   <= '0;
         fr_q.valid  <= 1'b0;
         skid_q      <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         disc_addr_q <= disc_addr_d;
         fr_q        <= fr_d;
         skid_q      <= skid_d;
      end
   end

   assign IMEM_REQ  = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
   assign IMEM_ADDR = (state_q == ST_DISCARD) ? disc_addr_q : pc_q;
   assign FR_MEM    = fr_q.mem;
   assign FR_PC     = fr_q.pc;
   assign FR_PC_4   = fr_q.pc_4;
   assign FR_VALID  = fr_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Two instances: dut_a (RESET_VECTOR=0) carries the main directed sequence
//   with an in-order scoreboard of expected FR_PC values; dut_b
//   (RESET_VECTOR=0x200) covers the asynchronous mid-wait reset. Memory
//   returns the address as data and can insert wait states for one chosen
//   address.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- dut_a ----------------
   logic        rst_a, stall_a, redir_a, req_a, ack_a, fr_valid_a;
   logic [31:0] redir_pc_a, addr_a, data_a, fr_mem_a, fr_pc_a, fr_pc4_a;
   logic [31:0] wait_addr_a;
   int          wait_n_a, cnt_a;

   fetch_stage #(.RESET_VECTOR(32'h0000_0000), .NOP_INSTR(NOP)) dut_a (
      .REG_CLOCK(clk), .REG_RESET(rst_a), .STALL(stall_a),
      .REDIRECT_EN(redir_a), .REDIRECT_PC(redir_pc_a),
      .IMEM_REQ(req_a), .IMEM_ADDR(addr_a), .IMEM_ACK(ack_a), .IMEM_DATA(data_a),
      .FR_MEM(fr_mem_a), .FR_PC(fr_pc_a), .FR_PC_4(fr_pc4_a), .FR_VALID(fr_valid_a)
   );

   assign ack_a  = req_a && (cnt_a >= ((addr_a == wait_addr_a) ? wait_n_a : 0));
   assign data_a = addr_a;
   always @(posedge clk or posedge rst_a)
      if (rst_a) cnt_a <= 0;
      else if (req_a && !ack_a) cnt_a <= cnt_a + 1;
      else cnt_a <= 0;

   // ---------------- dut_b ----------------
   logic        rst_b, stall_b, redir_b, req_b, ack_b, fr_valid_b;
   logic [31:0] redir_pc_b, addr_b, data_b, fr_mem_b, fr_pc_b, fr_pc4_b;
   logic [31:0] wait_addr_b;
   int          wait_n_b, cnt_b;

   fetch_stage #(.RESET_VECTOR(32'h0000_0200), .NOP_INSTR(NOP)) dut_b (
      .REG_CLOCK(clk), .REG_RESET(rst_b), .STALL(stall_b),
      .REDIRECT_EN(redir_b), .REDIRECT_PC(redir_pc_b),
      .IMEM_REQ(req_b), .IMEM_ADDR(addr_b), .IMEM_ACK(ack_b), .IMEM_DATA(data_b),
      .FR_MEM(fr_mem_b), .FR_PC(fr_pc_b), .FR_PC_4(fr_pc4_b), .FR_VALID(fr_valid_b)
   );

   assign ack_b  = req_b && (cnt_b >= ((addr_b == wait_addr_b) ? wait_n_b : 0));
   assign data_b = addr_b;
   always @(posedge clk or posedge rst_b)
      if (rst_b) cnt_b <= 0;
      else if (req_b && !ack_b) cnt_b <= cnt_b + 1;
      else cnt_b <= 0;

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_req"},   {31'd0, req_a},      32'd0);
      chk({tag, "_addr"},  addr_a,              32'h0);
      chk({tag, "_valid"}, {31'd0, fr_valid_a}, 32'd0);
      chk({tag, "_mem"},   fr_mem_a,            NOP);
      chk({tag, "_pc"},    fr_pc_a,             32'h0);
      chk({tag, "_pc4"},   fr_pc4_a,            32'h0);
   endtask

   // Scoreboard: a new instruction is on FR whenever it is valid and the
   // previous cycle did not hold a valid register under STALL.
   logic [31:0] exp_q[$];
   logic        prev_v = 1'b0;
   logic        prev_s = 1'b0;
   logic [31:0] exp_pc;

   always @(negedge clk) begin
      if (rst_a) begin
         prev_v = 1'b0;
         prev_s = 1'b0;
      end else begin
         if (fr_valid_a && !(prev_v && prev_s)) begin
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++;
               $error("FAIL sb_unexpected observed_pc=%h expected=none", fr_pc_a);
            end
            if (exp_q.size() > 0) begin
               exp_pc = exp_q.pop_front();
               chk("sb_pc",   fr_pc_a,  exp_pc);
               chk("sb_mem",  fr_mem_a, exp_pc);
               chk("sb_pc4",  fr_pc4_a, exp_pc + 32'd4);
            end
         end
         prev_v = fr_valid_a;
         prev_s = stall_a;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b1; stall_a = 1'b0; redir_a = 1'b0; redir_pc_a = '0;
      rst_b = 1'b1; stall_b = 1'b0; redir_b = 1'b0; redir_pc_b = '0;
      wait_addr_a = 32'h5555_5550; wait_n_a = 0;
      wait_addr_b = 32'h5555_5550; wait_n_b = 0;
      repeat (2) tick();

      // Reset state
      chk_reset_a("rst");

      // Zero-wait streaming: 0,4,8,12 on consecutive cycles
      exp_q.push_back(32'h0);  exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);  exp_q.push_back(32'hC);
      rst_a = 1'b0;
      tick();  // IDLE -> FETCH
      chk("t1_req",   {31'd0, req_a},      32'd1);
      chk("t1_addr",  addr_a,              32'h0);
      chk("t1_v0",    {31'd0, fr_valid_a}, 32'd0);
      tick();
      chk("t1_v1",    {31'd0, fr_valid_a}, 32'd1);
      chk("t1_pc0",   fr_pc_a,             32'h0);
      repeat (3) tick();
      chk("t1_pc12",  fr_pc_a,             32'hC);
      @(negedge clk); #1;
      rst_a = 1'b1; #1;
      chk_reset_a("t1_async");
      chk("t1_drain", 32'(exp_q.size()),   32'd0);

      // 2 wait states at 0x8, then stall/skid, redirect, flush, wrap
      wait_addr_a = 32'h8; wait_n_a = 2;
      exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
      exp_q.push_back(32'hC);  exp_q.push_back(32'h10); exp_q.push_back(32'h14);
      exp_q.push_back(32'h18); exp_q.push_back(32'h1C); exp_q.push_back(32'h100);
      exp_q.push_back(32'h300); exp_q.push_back(32'h304);
      exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0);
      tick();
      rst_a = 1'b0;
      tick(); tick();                                       // C1, C2
      tick();                                               // C3
      chk("t2_addr_w0", addr_a,              32'h8);
      chk("t2_req_w0",  {31'd0, req_a},      32'd1);
      tick();                                               // C4
      chk("t2_addr_w1", addr_a,              32'h8);
      chk("t2_v_wait",  {31'd0, fr_valid_a}, 32'd0);
      chk("t2_mem_nop", fr_mem_a,            NOP);
      tick();                                               // C5
      chk("t2_addr_w2", addr_a,              32'h8);
      tick();                                               // C6
      chk("t2_v8",      {31'd0, fr_valid_a}, 32'd1);
      chk("t2_pc8",     fr_pc_a,             32'h8);
      wait_addr_a = 32'h20; wait_n_a = 3;

      // STALL for 3 cycles while the ACK for 0x10 arrives
      tick();                                               // C7
      chk("t3_pcC",     fr_pc_a,             32'hC);
      stall_a = 1'b1;
      tick();                                               // C8
      chk("t3_hold_req", {31'd0, req_a},     32'd0);
      chk("t3_hold_pc",  fr_pc_a,            32'hC);
      chk("t3_hold_v",   {31'd0, fr_valid_a}, 32'd1);
      tick();                                               // C9
      chk("t3_hold_pc2", fr_pc_a,            32'hC);
      tick();                                               // C10
      chk("t3_hold_pc3", fr_pc_a,            32'hC);
      stall_a = 1'b0;
      tick();                                               // C11
      chk("t3_pc10",    fr_pc_a,             32'h10);
      chk("t3_addr14",  addr_a,              32'h14);
      tick();                                               // C12
      chk("t3_pc14",    fr_pc_a,             32'h14);

      // Redirect to 0x103 while the request for 0x20 is outstanding
      tick(); tick();                                       // C13, C14
      chk("t4_pc1C",    fr_pc_a,             32'h1C);
      chk("t4_addr20",  addr_a,              32'h20);
      redir_a = 1'b1; redir_pc_a = 32'h103;
      tick();                                               // C15
      redir_a = 1'b0;
      chk("t4_v0",      {31'd0, fr_valid_a}, 32'd0);
      chk("t4_disc_addr", addr_a,            32'h20);
      chk("t4_disc_req", {31'd0, req_a},     32'd1);
      tick(); tick();                                       // C16, C17
      chk("t4_disc_addr2", addr_a,           32'h20);
      tick();                                               // C18
      chk("t4_addr100", addr_a,              32'h100);
      tick();                                               // C19
      chk("t4_pc100",   fr_pc_a,             32'h100);

      // Fill the skid, then redirect and STALL in the same cycle
      stall_a = 1'b1;
      tick();                                               // C20
      chk("t5_hold_req", {31'd0, req_a},     32'd0);
      redir_a = 1'b1; redir_pc_a = 32'h300;
      tick();                                               // C21
      redir_a = 1'b0;
      chk("t5_v0",      {31'd0, fr_valid_a}, 32'd0);
      chk("t5_mem_nop", fr_mem_a,            NOP);
      chk("t5_addr300", addr_a,              32'h300);
      tick();                                               // C22
      chk("t5_pc300",   fr_pc_a,             32'h300);
      stall_a = 1'b0;
      tick();                                               // C23
      chk("t5_pc304",   fr_pc_a,             32'h304);

      // PC wrap without reset
      redir_a = 1'b1; redir_pc_a = 32'hFFFF_FFF8;
      tick();                                               // C24
      redir_a = 1'b0;
      chk("t6_addr",    addr_a,              32'hFFFF_FFF8);
      tick(); tick();                                       // C25, C26
      chk("t6_pcFC",    fr_pc_a,             32'hFFFF_FFFC);
      chk("t6_pc4wrap", fr_pc4_a,            32'h0);
      chk("t6_addr0",   addr_a,              32'h0);
      tick();                                               // C27
      chk("t6_pc0",     fr_pc_a,             32'h0);
      @(negedge clk); #1;
      rst_a = 1'b1;
      chk("t6_drain",   32'(exp_q.size()),   32'd0);

      // dut_b: asynchronous reset mid-wait at PC 0xFFFF_FFFC
      tick();
      rst_b = 1'b0;
      tick();
      chk("t7_addr200", addr_b,              32'h200);
      redir_b = 1'b1; redir_pc_b = 32'hFFFF_FFFC;
      wait_addr_b = 32'hFFFF_FFFC; wait_n_b = 5;
      tick();
      redir_b = 1'b0;
      chk("t7_addrFC",  addr_b,              32'hFFFF_FFFC);
      chk("t7_v0",      {31'd0, fr_valid_b}, 32'd0);
      tick();
      chk("t7_reqFC",   {31'd0, req_b},      32'd1);
      #2; rst_b = 1'b1; #1;
      chk("t7_ar_req",  {31'd0, req_b},      32'd0);
      chk("t7_ar_addr", addr_b,              32'h200);
      chk("t7_ar_v",    {31'd0, fr_valid_b}, 32'd0);
      chk("t7_ar_mem",  fr_mem_b,            NOP);
      chk("t7_ar_pc",   fr_pc_b,             32'h0);
      chk("t7_ar_pc4",  fr_pc4_b,            32'h0);
      rst_b = 1'b0;
      tick();
      chk("t7_rs_req",  {31'd0, req_b},      32'd1);
      chk("t7_rs_addr", addr_b,              32'h200);
      tick();
      chk("t7_rs_v",    {31'd0, fr_valid_b}, 32'd1);
      chk("t7_rs_pc",   fr_pc_b,             32'h200);
      chk("t7_rs_mem",  fr_mem_b,            32'h200);
      chk("t7_rs_pc4",  fr_pc4_b,            32'h204);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
